fib_seq_engine: RTL and testbench
=================================

// Module: fib_seq_engine
// PURPOSE
//  Parametrised integer-sequence engine: computes element N of Fibonacci (F0=0, F1=1) or Lucas (L0=2, L1=1).
//  Requests and responses use valid/ready handshakes. One addition per cycle.
//  Overflow is flagged per result; wrap or saturate is selectable at elaboration. A request can be aborted.
//  Sits behind the control/register block as a shared arithmetic worker.
// PARAMETERS
//  WIDTH     16  data width of sequence values and resp_value
//  IDX_W     5   width of requested index N (0 .. 2**IDX_W-1)
//  SATURATE  0   0: results wrap modulo 2**WIDTH; 1: results clamp to all-ones
// PORTS
//  clk         in   1      clock
//  reset       in   1      synchronous, active-high
//  req_valid   in   1      request present
//  req_ready   out  1      engine idle and able to accept
//  req_idx     in   IDX_W  index N
//  req_mode    in   1      0 Fibonacci, 1 Lucas
//  abort       in   1      cancel in-flight computation
//  busy        out  1      high while computing (WORK)
//  resp_valid  out  1      result available
//  resp_ready  in   1      consumer accepts result
//  resp_value  out  WIDTH  X(N), wrapped or saturated
//  resp_ovf    out  1      true X(N) >= 2**WIDTH
// BEHAVIOUR
//  - Reset: state IDLE; a, b, ctr, ovf_a, ovf_b cleared.
//    Outputs during/after reset: req_ready=0 while reset high, then 1; busy=0; resp_valid=0; resp_value=0; resp_ovf=0.
//  - States IDLE, WORK, DONE. req_ready=(state==IDLE)&&!reset; busy=(state==WORK); resp_valid=(state==DONE).
//  - IDLE: on req_valid&&req_ready, load a=X0, b=X1 per req_mode, ctr=req_idx, ovf_a=ovf_b=0, go to WORK.
//  - WORK, ctr!=0: a<=b; b<=a+b; ctr<=ctr-1.
//    ovf_b<=carry|ovf_a|ovf_b; ovf_a<=ovf_b.
//  - WORK, ctr==0: go to DONE. No arithmetic update.
//  - Latency: if the accept cycle is T, resp_valid first rises in cycle T+N+2. N=0 therefore gives T+2.
//  - DONE: resp_value=a and resp_ovf=ovf_a, held stable until resp_valid&&resp_ready.
//    On that handshake go to IDLE. req_ready rises the following cycle; no same-cycle turnaround.
//  - Sum rules: computed at WIDTH+1 bits; the carry is the MSB.
//    SATURATE=0: b gets the low WIDTH bits.
//    SATURATE=1: b gets all-ones when carry|ovf_a|ovf_b is set.
//  - Overflow tagging: ovf follows the value through the a/b shift. Overflow of X(N+1) never flags X(N).
//  - abort: in WORK, next state IDLE and no response is produced. Ignored in IDLE and DONE.
//    abort wins over a WORK->DONE transition in the same cycle.
//  - reset mid-operation: takes priority over everything. Any pending response is dropped.
//  - resp_ready while not DONE: ignored. req_valid while not IDLE: ignored, and the request is not accepted.
// STRUCTURE
//  - fib_pkg holds:
//    - typedef enum logic [1:0] {IDLE, WORK, DONE} fib_state_t;
//    - typedef enum logic {MODE_FIB, MODE_LUCAS} fib_mode_t;
//    - seed constants FIB_X0=0, FIB_X1=1, LUC_X0=2, LUC_X1=1.
//  - Sub-module fib_sat_add #(WIDTH, SATURATE): inputs a, b, ovf_in; outputs sum, ovf_out (combinational).
//  - Top-level: FSM, counter, a/b/ovf registers, handshake logic.
// TESTING (WIDTH=16, IDX_W=5)
//  - Fib N=0, 1, 2, 10, 24 -> resp_value 0, 1, 1, 55, 46368; resp_ovf=0; resp_valid first high at T+N+2.
//  - Lucas N=0, 5, 23 -> 2, 11, 64079, ovf=0.
//  - Lucas N=24 -> ovf=1, resp_value 38146 (SATURATE=0) or 65535 (SATURATE=1).
//  - Fib N=25 -> resp_ovf=1; resp_value 9489 (SATURATE=0) or 65535 (SATURATE=1).
//    Fib N=31 with SATURATE=1 -> 65535, ovf=1.
//  - Backpressure: hold resp_ready=0 for 10 cycles in DONE -> resp_value/ovf stable and req_ready=0.
//    A new req_valid is not accepted until the cycle after the response handshake.
//  - abort in 3rd WORK cycle of Fib N=20 -> no resp_valid; req_ready=1 next cycle.
//    A following N=7 request returns 13.
//  - reset asserted mid-WORK and in DONE -> next cycle resp_valid=0, busy=0, resp_value=0.
//    A following Fib N=3 returns 2.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared types and seed constants for the Fibonacci/Lucas sequence engine.
package fib_pkg;

  typedef enum logic [1:0] {IDLE, WORK, DONE} fib_state_t;
  typedef enum logic {MODE_FIB, MODE_LUCAS} fib_mode_t;

  localparam int FIB_X0 = 0;
  localparam int FIB_X1 = 1;
  localparam int LUC_X0 = 2;
  localparam int LUC_X1 = 1;

endpackage

// File: rtl/fib_sat_add.sv
// One-step sequence adder: WIDTH+1 bit sum whose carry feeds a sticky overflow tag.
// In saturating builds, any overflow on either operand or on this sum pins the result to all-ones.
module fib_sat_add #(
  parameter int WIDTH    = 16,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ovf_in,
  output logic [WIDTH-1:0] sum,
  output logic             ovf_out
);

  logic [WIDTH:0] full;

  assign full    = {1'b0, a} + {1'b0, b};
  assign ovf_out = full[WIDTH] | ovf_in;

  always_comb begin
    sum = full[WIDTH-1:0];
    if (SATURATE != 0 && ovf_out) sum = '1;
  end

endmodule

// File: rtl/fib_seq_engine.sv
// Computes element N of the Fibonacci or Lucas sequence, one addition per cycle.
// Request and response each use the same handshake rule, stated once below.
module fib_seq_engine
  import fib_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int IDX_W    = 5,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [IDX_W-1:0] req_idx,
  input  logic             req_mode,
  input  logic             abort,
  output logic             busy,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_value,
  output logic             resp_ovf,
  output logic [1:0]       dbg_state
);

  // Handshake rule: a transfer happens on a rising clk edge where valid && ready.
  // A producer keeps valid and its payload stable until the transfer completes.

  fib_state_t       state;
  fib_state_t       next_state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [IDX_W-1:0] ctr;
  logic             ovf_a;
  logic             ovf_b;
  logic [WIDTH-1:0] sum;
  logic             sum_ovf;
  logic             accept;
  logic             step;
  logic [WIDTH-1:0] seed_x0;
  logic [WIDTH-1:0] seed_x1;

  fib_sat_add #(
    .WIDTH   (WIDTH),
    .SATURATE(SATURATE)
  ) u_add (
    .a      (a),
    .b      (b),
    .ovf_in (ovf_a | ovf_b),
    .sum    (sum),
    .ovf_out(sum_ovf)
  );

  assign req_ready  = (state == IDLE) && !reset;
  assign busy       = (state == WORK);
  assign resp_valid = (state == DONE);
  assign resp_value = resp_valid ? a : '0;
  assign resp_ovf   = resp_valid & ovf_a;
  assign dbg_state  = state;

  assign accept = req_valid && req_ready;
  assign step   = (state == WORK) && !abort && (ctr != '0);

  always_comb begin
    seed_x0 = WIDTH'(FIB_X0);
    seed_x1 = WIDTH'(FIB_X1);
    if (fib_mode_t'(req_mode) == MODE_LUCAS) begin
      seed_x0 = WIDTH'(LUC_X0);
      seed_x1 = WIDTH'(LUC_X1);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = WORK;
      // abort outranks the finish transition so a cancelled job never responds
      WORK: begin
        if (abort)           next_state = IDLE;
        else if (ctr == '0)  next_state = DONE;
      end
      DONE: if (resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      ctr   <= '0;
      ovf_a <= 1'b0;
      ovf_b <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        a     <= seed_x0;
        b     <= seed_x1;
        ctr   <= req_idx;
        ovf_a <= 1'b0;
        ovf_b <= 1'b0;
      end else if (step) begin
        // overflow tags shift with their values so X(N+1) never taints X(N)
        a     <= b;
        b     <= sum;
        ctr   <= ctr - 1'b1;
        ovf_a <= ovf_b;
        ovf_b <= sum_ovf;
      end
    end
  end

endmodule

// File: tb/tb_fib_seq_engine.sv
// Bench for fib_seq_engine: a wrapping and a saturating instance share one stimulus stream.
module tb_fib_seq_engine;
  import fib_pkg::*;

  localparam int WIDTH = 16;
  localparam int IDX_W = 5;
  localparam int TMO   = 200;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             req_valid;
  logic [IDX_W-1:0] req_idx;
  logic             req_mode;
  logic             abort;
  logic             resp_ready;

  logic             req_ready_w, busy_w, resp_valid_w, resp_ovf_w;
  logic [WIDTH-1:0] resp_value_w;
  logic [1:0]       dbg_state_w;
  logic             req_ready_s, busy_s, resp_valid_s, resp_ovf_s;
  logic [WIDTH-1:0] resp_value_s;
  logic [1:0]       dbg_state_s;

  fib_seq_engine #(.WIDTH(WIDTH), .IDX_W(IDX_W), .SATURATE(0)) u_dut_wrap (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_w),
    .req_idx(req_idx), .req_mode(req_mode), .abort(abort), .busy(busy_w),
    .resp_valid(resp_valid_w), .resp_ready(resp_ready), .resp_value(resp_value_w),
    .resp_ovf(resp_ovf_w), .dbg_state(dbg_state_w)
  );

  fib_seq_engine #(.WIDTH(WIDTH), .IDX_W(IDX_W), .SATURATE(1)) u_dut_sat (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_s),
    .req_idx(req_idx), .req_mode(req_mode), .abort(abort), .busy(busy_s),
    .resp_valid(resp_valid_s), .resp_ready(resp_ready), .resp_value(resp_value_s),
    .resp_ovf(resp_ovf_s), .dbg_state(dbg_state_s)
  );

  // scoreboard entry: {ovf, wrapped value, saturated value}
  logic [2*WIDTH:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int accept_cyc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2*WIDTH:0] model(input int idx, input bit lucas);
    longint x0, x1, t;
    logic ovf;
    logic [WIDTH-1:0] wrap, sat;
    x0 = lucas ? 2 : 0;
    x1 = 1;
    for (int k = 0; k < idx; k++) begin
      t  = x0 + x1;
      x0 = x1;
      x1 = t;
    end
    ovf  = (x0 >= (64'd1 << WIDTH));
    wrap = WIDTH'(x0 % (64'd1 << WIDTH));
    sat  = ovf ? '1 : wrap;
    return {ovf, wrap, sat};
  endfunction

  task automatic check_idle_after_drop(input string tag);
    check({tag, "_resp_valid_w"}, resp_valid_w, 0);
    check({tag, "_resp_valid_s"}, resp_valid_s, 0);
    check({tag, "_busy_w"}, busy_w, 0);
    check({tag, "_busy_s"}, busy_s, 0);
    check({tag, "_resp_value_w"}, resp_value_w, 0);
    check({tag, "_resp_value_s"}, resp_value_s, 0);
  endtask

  // driver: present one request and wait for its acceptance; ends on a negedge
  task automatic issue(input int idx, input bit lucas, input bit push);
    int n = 0;
    while (!req_ready_w && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_before_req", req_ready_w, 1);
    req_valid = 1'b1;
    req_idx   = IDX_W'(idx);
    req_mode  = lucas;
    @(negedge clk);
    req_valid  = 1'b0;
    accept_cyc = cyc;
    check("busy_after_accept_w", busy_w, 1);
    check("busy_after_accept_s", busy_s, 1);
    if (push) exp_q.push_back(model(idx, lucas));
  endtask

  // wait for the response, score it, optionally stall for hold cycles, then consume it
  task automatic collect(input int idx, input int hold);
    int n = 0;
    logic [2*WIDTH:0] e;
    logic [WIDTH-1:0] v0, v1;
    logic o0, o1;
    while (!resp_valid_w && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check("resp_valid_seen", resp_valid_w, 1);
    check("resp_valid_sat_inst", resp_valid_s, 1);
    check("latency", cyc - (accept_cyc - 1), idx + 2);
    check("scoreboard_depth", exp_q.size(), 1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    check("value_wrap", resp_value_w, e[2*WIDTH-1:WIDTH]);
    check("ovf_wrap", resp_ovf_w, e[2*WIDTH]);
    check("value_sat", resp_value_s, e[WIDTH-1:0]);
    check("ovf_sat", resp_ovf_s, e[2*WIDTH]);
    v0 = resp_value_w; o0 = resp_ovf_w;
    v1 = resp_value_s; o1 = resp_ovf_s;
    for (int i = 0; i < hold; i++) begin
      req_valid  = 1'b1;
      abort      = (i == 3);
      resp_ready = 1'b0;
      @(negedge clk);
      check("hold_value_w", resp_value_w, v0);
      check("hold_ovf_w", resp_ovf_w, o0);
      check("hold_value_s", resp_value_s, v1);
      check("hold_ovf_s", resp_ovf_s, o1);
      check("hold_req_ready", req_ready_w, 0);
      check("hold_state", dbg_state_w, 2'(DONE));
    end
    abort      = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    check("post_hs_resp_valid", resp_valid_w, 0);
    check("post_hs_req_ready", req_ready_w, 1);
    check("post_hs_state_idle", dbg_state_w, 2'(IDLE));
  endtask

  int fib_tab[7] = '{0, 1, 2, 10, 24, 25, 31};
  int luc_tab[4] = '{0, 5, 23, 24};

  initial begin
    bit saw_resp;
    int n;
    int ridx;
    bit rmode;
    reset = 1'b1; req_valid = 1'b0; req_idx = '0; req_mode = 1'b0;
    abort = 1'b0; resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready_w, 0);
    check_idle_after_drop("rst");
    check("rst_resp_ovf", resp_ovf_w, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", req_ready_w, 1);
    check("post_rst_state", dbg_state_w, 2'(IDLE));

    foreach (fib_tab[i]) begin
      issue(fib_tab[i], 1'b0, 1'b1);
      collect(fib_tab[i], 0);
    end
    foreach (luc_tab[i]) begin
      issue(luc_tab[i], 1'b1, 1'b1);
      collect(luc_tab[i], 0);
    end

    // backpressure with stray req_valid and abort while DONE
    issue(12, 1'b0, 1'b1);
    collect(12, 10);

    // abort in the third WORK cycle
    issue(20, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_resp_valid", resp_valid_w, 0);
    check("abort_busy", busy_w, 0);
    check("abort_req_ready", req_ready_w, 1);
    saw_resp = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (resp_valid_w || resp_valid_s) saw_resp = 1'b1;
    end
    check("abort_no_resp", saw_resp, 0);
    issue(7, 1'b0, 1'b1);
    collect(7, 0);

    // reset mid-WORK
    issue(20, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle_after_drop("rst_work");
    reset = 1'b0;
    @(negedge clk);

    // reset while DONE
    issue(1, 1'b0, 1'b0);
    n = 0;
    while (!resp_valid_w && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check("done_before_reset", resp_valid_w, 1);
    reset = 1'b1;
    @(negedge clk);
    check_idle_after_drop("rst_done");
    reset = 1'b0;
    @(negedge clk);
    issue(3, 1'b0, 1'b1);
    collect(3, 0);

    // random requests
    repeat (6) begin
      ridx  = $urandom_range(0, 31);
      rmode = 1'($urandom_range(0, 1));
      issue(ridx, rmode, 1'b1);
      collect(ridx, $urandom_range(0, 3));
    end

    check("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
